// File: rtl/set_assoc_directory_if.sv
// Request / response / victim bundle for the set-associative coherence
// directory.
//   master : requester side. Drives the request and evict_ready, receives
//            the response and the victim.
//   slave  : directory side.
interface set_assoc_directory_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int NUM_WAYS    = 4,
  parameter int ADDR_W      = 64
);
  localparam int WAY_W = $clog2(NUM_WAYS);

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_op;        // 0 = LOOKUP, 1 = UPDATE
  logic [ADDR_W-1:0]      req_addr;
  logic [2:0]             req_state;
  logic [NUM_CLIENTS-1:0] req_presence;
  logic [NUM_CLIENTS-1:0] req_tip;

  logic                   resp_valid;
  logic                   resp_hit;
  logic [WAY_W-1:0]       resp_way;
  logic [2:0]             resp_state;
  logic [NUM_CLIENTS-1:0] resp_presence;
  logic [NUM_CLIENTS-1:0] resp_tip;

  logic                   evict_valid;
  logic                   evict_ready;
  logic [ADDR_W-1:0]      evict_addr;
  logic [2:0]             evict_state;
  logic [NUM_CLIENTS-1:0] evict_presence;
  logic [NUM_CLIENTS-1:0] evict_tip;

  modport master (
    output req_valid, req_op, req_addr, req_state, req_presence, req_tip, evict_ready,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_state, resp_presence, resp_tip,
    input  evict_valid, evict_addr, evict_state, evict_presence, evict_tip
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_state, req_presence, req_tip, evict_ready,
    output req_ready, resp_valid, resp_hit, resp_way, resp_state, resp_presence, resp_tip,
    output evict_valid, evict_addr, evict_state, evict_presence, evict_tip
  );
endinterface

// File: rtl/set_assoc_directory.sv
// Set-associative coherence directory.
// Each entry holds a tag, a 3-bit directory state, and presence and tip
// vectors with one bit per client. Victims are chosen by a round-robin
// pointer kept for each set.
//   clk, rst_n     : single clock, asynchronous active-low reset
//   dir (slave)    : request, response and victim handshake
//   stat_evictions : saturating count of completed evictions
// The tag compare runs on the live request address in the cycle the request
// is accepted. The array cannot change while the FSM sits in IDLE, so that
// result is the same as a compare on the registered address. All outputs
// come straight from registers.
module set_assoc_directory #(
  parameter int NUM_CLIENTS = 2,
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4,
  parameter int ADDR_W      = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  set_assoc_directory_if.slave dir,
  output logic [15:0]          stat_evictions
);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int TAG_W = ADDR_W - SET_W;
  localparam logic [2:0] DIR_STATE_INVALID = 3'd0;

  typedef enum logic [1:0] {IDLE, RESP, EVICT} st_t;
  st_t st;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]                  valid;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_W-1:0]       tags;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][2:0]             dstate;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][NUM_CLIENTS-1:0] pres;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][NUM_CLIENTS-1:0] tip;
  logic [NUM_SETS-1:0][WAY_W-1:0]                     rr;

  // Request captured on acceptance.
  logic [SET_W-1:0]       idx_q;
  logic [TAG_W-1:0]       tag_q;
  logic [2:0]             state_q;
  logic [NUM_CLIENTS-1:0] pres_q, tip_q;
  logic                   wr_q;   // write or allocate the entry at the end of RESP
  logic                   clr_q;  // invalidate the entry at the end of RESP

  logic [SET_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit, l_free;
  logic [WAY_W-1:0] l_hit_way, l_free_way;

  assign l_idx = dir.req_addr[SET_W-1:0];
  assign l_tag = dir.req_addr[ADDR_W-1:SET_W];
  assign dir.req_ready = (st == IDLE);

  // The loop runs from the top way down to way 0, so the last assignment
  // wins and l_free_way ends up as the lowest invalid way.
  always_comb begin
    l_hit = 1'b0; l_hit_way = '0; l_free = 1'b0; l_free_way = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (valid[l_idx][w] && tags[l_idx][w] == l_tag) begin
        l_hit = 1'b1; l_hit_way = WAY_W'(w);
      end
      if (!valid[l_idx][w]) begin
        l_free = 1'b1; l_free_way = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      valid <= '0; tags <= '0; dstate <= '0; pres <= '0; tip <= '0; rr <= '0;
      idx_q <= '0; tag_q <= '0; state_q <= '0; pres_q <= '0; tip_q <= '0;
      wr_q <= 1'b0; clr_q <= 1'b0;
      stat_evictions <= '0;
      dir.resp_valid <= 1'b0; dir.resp_hit <= 1'b0; dir.resp_way <= '0;
      dir.resp_state <= '0; dir.resp_presence <= '0; dir.resp_tip <= '0;
      dir.evict_valid <= 1'b0; dir.evict_addr <= '0; dir.evict_state <= '0;
      dir.evict_presence <= '0; dir.evict_tip <= '0;
    end else begin
      dir.resp_valid <= 1'b0;
      case (st)
        IDLE: if (dir.req_valid) begin
          idx_q <= l_idx; tag_q <= l_tag;
          state_q <= dir.req_state; pres_q <= dir.req_presence; tip_q <= dir.req_tip;
          // The response reports the entry contents before any write.
          dir.resp_hit      <= l_hit;
          dir.resp_state    <= l_hit ? dstate[l_idx][l_hit_way] : DIR_STATE_INVALID;
          dir.resp_presence <= l_hit ? pres[l_idx][l_hit_way] : '0;
          dir.resp_tip      <= l_hit ? tip[l_idx][l_hit_way] : '0;
          wr_q <= 1'b0; clr_q <= 1'b0;
          dir.resp_way <= l_hit ? l_hit_way : '0;
          if (!dir.req_op) begin
            dir.resp_valid <= 1'b1; st <= RESP;
          end else if (l_hit) begin
            clr_q <= (dir.req_state == DIR_STATE_INVALID);
            wr_q  <= (dir.req_state != DIR_STATE_INVALID);
            dir.resp_valid <= 1'b1; st <= RESP;
          end else if (dir.req_state == DIR_STATE_INVALID || l_free) begin
            // A miss that writes INVALID allocates nothing.
            wr_q <= (dir.req_state != DIR_STATE_INVALID);
            if (dir.req_state != DIR_STATE_INVALID) dir.resp_way <= l_free_way;
            dir.resp_valid <= 1'b1; st <= RESP;
          end else begin
            // The set is full, so present the round-robin victim.
            dir.resp_way       <= rr[l_idx];
            dir.evict_valid    <= 1'b1;
            dir.evict_addr     <= {tags[l_idx][rr[l_idx]], l_idx};
            dir.evict_state    <= dstate[l_idx][rr[l_idx]];
            dir.evict_presence <= pres[l_idx][rr[l_idx]];
            dir.evict_tip      <= tip[l_idx][rr[l_idx]];
            st <= EVICT;
          end
        end
        RESP: begin
          if (wr_q) begin
            valid[idx_q][dir.resp_way]  <= 1'b1;
            tags[idx_q][dir.resp_way]   <= tag_q;
            dstate[idx_q][dir.resp_way] <= state_q;
            pres[idx_q][dir.resp_way]   <= pres_q;
            tip[idx_q][dir.resp_way]    <= tip_q;
          end
          if (clr_q) valid[idx_q][dir.resp_way] <= 1'b0;
          wr_q <= 1'b0; clr_q <= 1'b0;
          st <= IDLE;
        end
        EVICT: if (dir.evict_ready) begin
          valid[idx_q][dir.resp_way]  <= 1'b1;
          tags[idx_q][dir.resp_way]   <= tag_q;
          dstate[idx_q][dir.resp_way] <= state_q;
          pres[idx_q][dir.resp_way]   <= pres_q;
          tip[idx_q][dir.resp_way]    <= tip_q;
          rr[idx_q] <= rr[idx_q] + 1'b1;  // power-of-two ways wrap naturally
          if (stat_evictions != 16'hFFFF) stat_evictions <= stat_evictions + 16'd1;
          dir.evict_valid <= 1'b0; dir.evict_addr <= '0; dir.evict_state <= '0;
          dir.evict_presence <= '0; dir.evict_tip <= '0;
          dir.resp_valid <= 1'b1;
          st <= RESP;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
